// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth mantissa multiplier: one Booth digit retired per cycle, exact 48-bit product.
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses the digit loop and goes straight to DONE.
module booth_mul_iter #(
  parameter int MAN_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_W-2:0]     frc_X,
  input  logic [MAN_W-2:0]     frc_Y,
  input  logic                 hid_X,
  input  logic                 hid_Y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*MAN_W-1:0]   frc_Z_full,
  output logic                 norm_n,
  output logic                 busy
);

  localparam int ITER  = (MAN_W + 2) / 2;
  localparam int ACC_W = 2 * MAN_W + 2;
  localparam int MY_W  = MAN_W + 3;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_count;
  logic signed [ACC_W-1:0]   r_acc;
  logic [MAN_W-1:0]          r_mx;
  logic [MY_W-1:0]           r_my;
  logic [2:0]                w_digit;
  logic signed [ACC_W-1:0]   w_pp;
  logic signed [ACC_W-1:0]   w_pp_sh;

  // Radix-4 Booth recoding of one overlapping 3-bit multiplier window.
  function automatic logic signed [ACC_W-1:0] booth_pp(input logic [2:0] d,
                                                       input logic [MAN_W-1:0] mx);
    logic signed [ACC_W-1:0] m;
    m = signed'({{(ACC_W-MAN_W){1'b0}}, mx});
    case (d)
      3'b001, 3'b010: return m;
      3'b011:         return m <<< 1;
      3'b100:         return -(m <<< 1);
      3'b101, 3'b110: return -m;
      default:        return '0;
    endcase
  endfunction

  assign w_digit = r_my[{r_count, 1'b0} +: 3];
  assign w_pp    = booth_pp(w_digit, r_mx);
  assign w_pp_sh = w_pp <<< {r_count, 1'b0};

  // State register: rst outranks flush, both return to IDLE.
  always_ff @(posedge clk) begin
    if (rst || flush) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) begin
`ifdef BOOTH_ZERO_SKIP_EN
        if (({hid_X, frc_X} == '0) || ({hid_Y, frc_Y} == '0)) w_state_nxt = S_DONE;
        else                                                  w_state_nxt = S_BUSY;
`else
        w_state_nxt = S_BUSY;
`endif
      end
      S_BUSY: if (r_count == CNT_W'(ITER - 1)) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch on accept, one digit accumulated per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mx    <= {hid_X, frc_X};
          r_my    <= {2'b00, hid_Y, frc_Y, 1'b0};
          r_acc   <= '0;
          r_count <= '0;
        end
        S_BUSY: begin
          r_acc   <= r_acc + w_pp_sh;
          r_count <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready   = (r_state == S_IDLE);
    busy       = (r_state == S_BUSY);
    out_valid  = (r_state == S_DONE);
    frc_Z_full = (r_state == S_DONE) ? r_acc[2*MAN_W-1:0] : '0;
    norm_n     = frc_Z_full[2*MAN_W-1];
  end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed self-checking bench for booth_mul_iter (default and BOOTH_ZERO_SKIP_EN builds).
module tb_booth_mul_iter;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, hid_X, hid_Y;
  logic [22:0] frc_X, frc_Y;
  logic        in_ready, out_valid, norm_n, busy;
  logic [47:0] frc_Z_full;

  int checks = 0;
  int errors = 0;

`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 14;
`endif

  booth_mul_iter dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .frc_X(frc_X), .frc_Y(frc_Y), .hid_X(hid_X), .hid_Y(hid_Y),
    .out_valid(out_valid), .out_ready(out_ready), .frc_Z_full(frc_Z_full),
    .norm_n(norm_n), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] golden(input logic hx, input logic [22:0] fx,
                                         input logic hy, input logic [22:0] fy);
    logic [47:0] a, b;
    a = {24'd0, hx, fx};
    b = {24'd0, hy, fy};
    return a * b;
  endfunction

  task automatic start_op(input logic hx, input logic [22:0] fx,
                          input logic hy, input logic [22:0] fy);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL start_in_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1; hid_X = hx; frc_X = fx; hid_Y = hy; frc_Y = fy;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the number of edges, accept edge inclusive, until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  task automatic run_check(input string nm, input logic hx, input logic [22:0] fx,
                           input logic hy, input logic [22:0] fy, input int exp_lat);
    int lat;
    logic [47:0] exp_z;
    exp_z = golden(hx, fx, hy, fy);
    start_op(hx, fx, hy, fy);
    wait_done(lat);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", nm, lat, exp_lat);
    end
    checks++;
    if (frc_Z_full !== exp_z) begin
      errors++; $display("FAIL %s_product got %h want %h", nm, frc_Z_full, exp_z);
    end
    checks++;
    if (norm_n !== exp_z[47]) begin
      errors++; $display("FAIL %s_norm_n got %b want %b", nm, norm_n, exp_z[47]);
    end
    checks++;
    if (dut.r_acc[49:48] !== 2'b00) begin
      errors++; $display("FAIL %s_acc_top got %b want 00", nm, dut.r_acc[49:48]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, norm_n} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got %b want 1000", {in_ready, out_valid, busy, norm_n});
    end
    checks++;
    if (frc_Z_full !== 48'h0) begin
      errors++; $display("FAIL reset_z got %h want 0", frc_Z_full);
    end
  endtask

  task automatic test_corners();
    run_check("min_norm", 1'b1, 23'h0, 1'b1, 23'h0, 14);
    checks++;
    if (golden(1'b1, 23'h0, 1'b1, 23'h0) !== 48'h4000_0000_0000) begin
      errors++; $display("FAIL model_min got %h want 400000000000", golden(1'b1, 23'h0, 1'b1, 23'h0));
    end
    run_check("max", 1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 14);
    checks++;
    if (golden(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF) !== 48'hFFFF_FE00_0001) begin
      errors++; $display("FAIL model_max got %h want FFFFFE000001", golden(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF));
    end
  endtask

  task automatic test_golden();
    run_check("gold_11", 1'b1, 23'h2DF854, 1'b1, 23'h490FDB, 14);
    run_check("gold_01", 1'b0, 23'h2DF854, 1'b1, 23'h490FDB, 14);
    run_check("mixed", 1'b1, 23'h555555, 1'b1, 23'h2AAAAA, 14);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [47:0] exp_z;
    exp_z = golden(1'b1, 23'h123456, 1'b1, 23'h654321);
    out_ready = 1'b0;
    start_op(1'b1, 23'h123456, 1'b1, 23'h654321);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; hid_X = 1'b1; frc_X = 23'h7FFFFF; hid_Y = 1'b1; frc_Y = 23'h000001;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        errors++; $display("FAIL stall_ctrl_%0d got %b want 10", i, {out_valid, in_ready});
      end
      checks++;
      if (frc_Z_full !== exp_z) begin
        errors++; $display("FAIL stall_z_%0d got %h want %h", i, frc_Z_full, exp_z);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL stall_release got %b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_abort(input logic use_flush);
    start_op(1'b1, 23'h2DF854, 1'b1, 23'h490FDB);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({busy, dut.r_count} !== 5'b1_0110) begin
      errors++; $display("FAIL abort_mid got %b want 10110", {busy, dut.r_count});
    end
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL abort_%0d got %b want 100", use_flush, {in_ready, out_valid, busy});
    end
    repeat (14) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL abort_spurious_%0d got %b want 0", use_flush, out_valid);
      end
    end
    run_check("after_abort", 1'b1, 23'h7FFFFF, 1'b0, 23'h400001, 14);
  endtask

  task automatic test_zero();
    run_check("zero_x", 1'b0, 23'h0, 1'b1, 23'h123456, ZLAT);
    run_check("zero_y", 1'b1, 23'h3ABCDE, 1'b0, 23'h0, ZLAT);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_a", 1'b1, 23'h000001, 1'b1, 23'h7FFFFE, 14);
    run_check("b2b_b", 1'b0, 23'h7FFFFF, 1'b0, 23'h7FFFFF, 14);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    hid_X = 1'b0; hid_Y = 1'b0; frc_X = '0; frc_Y = '0;
    test_reset();
    test_corners();
    test_golden();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_zero();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
